// File: rtl/std_lsu_ahb.sv
// std_lsu_ahb: single-outstanding load/store unit that turns register-level
// memory requests into AHB-Lite single transfers.
//
// Build option: define LSU_ALIGN_CHECK_EN to reject misaligned half/word
// requests as illegal. When it is left undefined, the low HADDR bits are
// cleared per size and a misaligned word load returns HRDATA rotated right
// by 8*addr[1:0] (ARM7 behaviour).
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req_*             request handshake (valid/ready), rd/wr, size in bytes,
//                     signed load, byte address, store data, destination id
//   HADDR..HWDATA     AHB-Lite master outputs
//   HRDATA/HREADY/HRESP  AHB-Lite slave response
//   rsp_*             one-cycle completion: load data, id, writeback, error
//   busy              high whenever the FSM is not in IDLE
module std_lsu_ahb (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_rd,
  input  logic [3:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd_id,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd_id,
  output logic        rsp_wb_en,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e      r_state;
  logic        r_rd;
  logic        r_wr;
  logic        r_signed;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd_id;
  logic        r_illegal;
  logic [31:0] r_rdata;
  logic        r_hresp;

  logic        w_size_ok;
  logic        w_align_ok;
  logic        w_legal;
  logic [2:0]  w_hsize;
  logic [31:0] w_addr_issue;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_rot;
  logic [31:0] w_load_data;

  // The response pulse occupies the cycle after RESP, so hold off a new
  // request until it has been seen.
  assign req_ready = (r_state == StIdle) && !rsp_valid;
  assign busy      = (r_state != StIdle);

  always_comb begin
    w_size_ok = 1'b1;
    w_hsize   = 3'b000;
    unique case (req_size)
      4'h1:    w_hsize = 3'b000;
      4'h2:    w_hsize = 3'b001;
      4'h4:    w_hsize = 3'b010;
      default: w_size_ok = 1'b0;
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  assign w_align_ok   = !(((req_size == 4'h2) && req_addr[0]) ||
                          ((req_size == 4'h4) && (req_addr[1:0] != 2'b00)));
  assign w_addr_issue = req_addr;
`else
  assign w_align_ok   = 1'b1;
  always_comb begin
    w_addr_issue = req_addr;
    if (req_size == 4'h2) w_addr_issue[0]   = 1'b0;
    if (req_size == 4'h4) w_addr_issue[1:0] = 2'b00;
  end
`endif

  assign w_legal = (req_rd ^ req_wr) && w_size_ok && w_align_ok;

  // Store data replicated across every byte lane the slave might sample.
  always_comb begin
    w_wdata_rep = r_wdata;
    unique case (HSIZE)
      3'b000:  w_wdata_rep = {4{r_wdata[7:0]}};
      3'b001:  w_wdata_rep = {2{r_wdata[15:0]}};
      default: w_wdata_rep = r_wdata;
    endcase
  end

  // Rotating right by the byte offset lands the addressed lane at bit 0 and
  // gives the ARM7 rotated result for misaligned words in one step.
  always_comb begin
    w_rot = r_rdata;
    unique case (r_addr_lo)
      2'd0: w_rot = r_rdata;
      2'd1: w_rot = {r_rdata[7:0],  r_rdata[31:8]};
      2'd2: w_rot = {r_rdata[15:0], r_rdata[31:16]};
      2'd3: w_rot = {r_rdata[23:0], r_rdata[31:24]};
    endcase
  end

  always_comb begin
    w_load_data = w_rot;
    unique case (HSIZE)
      3'b000:  w_load_data = {{24{r_signed & w_rot[7]}},  w_rot[7:0]};
      3'b001:  w_load_data = {{16{r_signed & w_rot[15]}}, w_rot[15:0]};
      default: w_load_data = w_rot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_signed  <= 1'b0;
      r_addr_lo <= 2'b00;
      r_wdata   <= '0;
      r_rd_id   <= '0;
      r_illegal <= 1'b0;
      r_rdata   <= '0;
      r_hresp   <= 1'b0;
      HADDR     <= '0;
      HTRANS    <= 2'b00;
      HWRITE    <= 1'b0;
      HSIZE     <= 3'b000;
      HBURST    <= 3'b000;
      HWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_rd_id <= '0;
      rsp_wb_en <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (req_valid && req_ready) begin
            r_rd      <= req_rd;
            r_wr      <= req_wr;
            r_signed  <= req_signed;
            r_addr_lo <= req_addr[1:0];
            r_wdata   <= req_wdata;
            r_rd_id   <= req_rd_id;
            r_hresp   <= 1'b0;
            if (w_legal) begin
              r_illegal <= 1'b0;
              r_state   <= StAddr;
              HTRANS    <= 2'b10;
              HADDR     <= w_addr_issue;
              HWRITE    <= req_wr;
              HSIZE     <= w_hsize;
              HBURST    <= 3'b000;
            end else begin
              r_illegal <= 1'b1;
              r_state   <= StResp;
            end
          end
        end
        StAddr: begin
          if (HREADY) begin
            r_state <= StData;
            HTRANS  <= 2'b00;
            if (r_wr) HWDATA <= w_wdata_rep;
          end
        end
        StData: begin
          if (HREADY) begin
            r_rdata <= HRDATA;
            r_hresp <= HRESP;
            r_state <= StResp;
          end
        end
        StResp: begin
          rsp_valid <= 1'b1;
          rsp_rd_id <= r_rd_id;
          rsp_err   <= r_illegal | r_hresp;
          rsp_wb_en <= r_rd & ~r_illegal & ~r_hresp;
          rsp_data  <= (r_rd && !r_illegal) ? w_load_data : 32'h0;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_std_lsu_ahb.sv
// Directed bench for std_lsu_ahb. The bench plays the AHB slave by driving
// HREADY/HRDATA/HRESP cycle by cycle. Cycle 0 is the accept cycle; the
// zero-wait response is expected in cycle 4.
module tb_std_lsu_ahb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic        req_rd = 1'b0;
  logic [3:0]  req_size = 4'h0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd_id = '0;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd_id;
  logic        rsp_wb_en;
  logic        rsp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  std_lsu_ahb u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_rd     (req_rd),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd_id  (req_rd_id),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_rd_id  (rsp_rd_id),
    .rsp_wb_en  (rsp_wb_en),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns in cycle 1.
  task automatic issue(input logic rd, input logic wr, input logic [3:0] size,
                       input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] id);
    int k = 0;
    while (!req_ready && k < 20) begin
      tick();
      k++;
    end
    check_eq("ready_before_issue", {31'b0, req_ready}, 32'd1);
    req_rd     = rd;
    req_wr     = wr;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd_id  = id;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    req_rd    = 1'b0;
    req_wr    = 1'b0;
  endtask

  // Advances until rsp_valid, counting cycles and NONSEQ cycles seen.
  task automatic wait_rsp(input int n0, output int n, output int ns);
    n  = n0;
    ns = 0;
    while (!rsp_valid && n < 24) begin
      if (HTRANS == 2'b10) ns++;
      tick();
      n++;
    end
    if (!rsp_valid) check_eq("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic after_rsp(input string tag);
    tick();
    check_eq({tag, "_pulse_one"}, {31'b0, rsp_valid}, 32'd0);
    check_eq({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    check_eq({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int ns;
    int pulses;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_htrans", {30'b0, HTRANS}, 32'd0);
    check_eq("rst_haddr", HADDR, 32'd0);
    check_eq("rst_hwdata", HWDATA, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_ready", {31'b0, req_ready}, 32'd1);

    // Zero-wait word load
    HREADY = 1'b1;
    HRDATA = 32'hDEADBEEF;
    issue(1'b1, 1'b0, 4'h4, 1'b0, 32'h100, 32'h0, 5'd3);
    check_eq("wl_htrans", {30'b0, HTRANS}, 32'h2);
    check_eq("wl_haddr", HADDR, 32'h100);
    check_eq("wl_hsize", {29'b0, HSIZE}, 32'h2);
    check_eq("wl_hwrite", {31'b0, HWRITE}, 32'h0);
    check_eq("wl_hburst", {29'b0, HBURST}, 32'h0);
    check_eq("wl_busy", {31'b0, busy}, 32'h1);
    check_eq("wl_not_ready", {31'b0, req_ready}, 32'h0);
    wait_rsp(1, n, ns);
    check_eq("wl_latency", n, 32'd4);
    check_eq("wl_nonseq_cycles", ns, 32'd1);
    check_eq("wl_data", rsp_data, 32'hDEADBEEF);
    check_eq("wl_wb_en", {31'b0, rsp_wb_en}, 32'd1);
    check_eq("wl_err", {31'b0, rsp_err}, 32'd0);
    check_eq("wl_rd_id", {27'b0, rsp_rd_id}, 32'd3);
    after_rsp("wl");

    // Signed and unsigned byte loads from lane 3
    HRDATA = 32'h80112233;
    issue(1'b1, 1'b0, 4'h1, 1'b1, 32'h203, 32'h0, 5'd5);
    check_eq("sb_haddr", HADDR, 32'h203);
    check_eq("sb_hsize", {29'b0, HSIZE}, 32'h0);
    wait_rsp(1, n, ns);
    check_eq("sb_data", rsp_data, 32'hFFFFFF80);
    check_eq("sb_rd_id", {27'b0, rsp_rd_id}, 32'd5);
    after_rsp("sb");
    issue(1'b1, 1'b0, 4'h1, 1'b0, 32'h203, 32'h0, 5'd6);
    wait_rsp(1, n, ns);
    check_eq("ub_data", rsp_data, 32'h00000080);

    // Signed halfword load from the upper half
    HRDATA = 32'h80017FFF;
    issue(1'b1, 1'b0, 4'h2, 1'b1, 32'h202, 32'h0, 5'd9);
    check_eq("sh_hsize", {29'b0, HSIZE}, 32'h1);
    wait_rsp(1, n, ns);
    check_eq("sh_data", rsp_data, 32'hFFFF8001);
    check_eq("sh_wb_en", {31'b0, rsp_wb_en}, 32'd1);

    // Halfword store with two wait states in the data phase
    issue(1'b0, 1'b1, 4'h2, 1'b0, 32'h42, 32'h0000ABCD, 5'd7);
    check_eq("hs_hsize", {29'b0, HSIZE}, 32'h1);
    check_eq("hs_hwrite", {31'b0, HWRITE}, 32'h1);
    check_eq("hs_haddr", HADDR, 32'h42);
    tick();
    HREADY = 1'b0;
    check_eq("hs_hwdata_c2", HWDATA, 32'hABCDABCD);
    check_eq("hs_htrans_c2", {30'b0, HTRANS}, 32'h0);
    tick();
    check_eq("hs_hwdata_c3", HWDATA, 32'hABCDABCD);
    check_eq("hs_busy_c3", {31'b0, busy}, 32'h1);
    tick();
    HREADY = 1'b1;
    check_eq("hs_hwdata_c4", HWDATA, 32'hABCDABCD);
    wait_rsp(4, n, ns);
    check_eq("hs_latency", n, 32'd6);
    check_eq("hs_wb_en", {31'b0, rsp_wb_en}, 32'd0);
    check_eq("hs_err", {31'b0, rsp_err}, 32'd0);
    check_eq("hs_data", rsp_data, 32'd0);
    check_eq("hs_rd_id", {27'b0, rsp_rd_id}, 32'd7);

    // Two-cycle error response on a word store
    issue(1'b0, 1'b1, 4'h4, 1'b0, 32'h300, 32'h12345678, 5'd2);
    tick();
    HREADY = 1'b0;
    HRESP  = 1'b1;
    check_eq("er_hwdata", HWDATA, 32'h12345678);
    tick();
    HREADY = 1'b1;
    tick();
    HRESP = 1'b0;
    wait_rsp(4, n, ns);
    check_eq("er_latency", n, 32'd5);
    check_eq("er_err", {31'b0, rsp_err}, 32'd1);
    check_eq("er_wb_en", {31'b0, rsp_wb_en}, 32'd0);
    after_rsp("er");

    // Illegal: read and write both set
    issue(1'b1, 1'b1, 4'h4, 1'b0, 32'h80, 32'h0, 5'd4);
    wait_rsp(1, n, ns);
    check_eq("rw_latency", n, 32'd2);
    check_eq("rw_nonseq_cycles", ns, 32'd0);
    check_eq("rw_err", {31'b0, rsp_err}, 32'd1);
    check_eq("rw_wb_en", {31'b0, rsp_wb_en}, 32'd0);
    check_eq("rw_data", rsp_data, 32'd0);
    check_eq("rw_rd_id", {27'b0, rsp_rd_id}, 32'd4);
    after_rsp("rw");

    // Illegal: size 3
    issue(1'b1, 1'b0, 4'h3, 1'b0, 32'h80, 32'h0, 5'd1);
    wait_rsp(1, n, ns);
    check_eq("sz_nonseq_cycles", ns, 32'd0);
    check_eq("sz_err", {31'b0, rsp_err}, 32'd1);

    // Misaligned word load at 0x101
    HRDATA = 32'h44332211;
    issue(1'b1, 1'b0, 4'h4, 1'b0, 32'h101, 32'h0, 5'd8);
`ifdef LSU_ALIGN_CHECK_EN
    wait_rsp(1, n, ns);
    check_eq("mw_nonseq_cycles", ns, 32'd0);
    check_eq("mw_err", {31'b0, rsp_err}, 32'd1);
    check_eq("mw_wb_en", {31'b0, rsp_wb_en}, 32'd0);
`else
    check_eq("mw_haddr", HADDR, 32'h100);
    wait_rsp(1, n, ns);
    check_eq("mw_data", rsp_data, 32'h11443322);
    check_eq("mw_err", {31'b0, rsp_err}, 32'd0);
    check_eq("mw_wb_en", {31'b0, rsp_wb_en}, 32'd1);
`endif

    // Reset in the middle of a stalled data phase
    issue(1'b1, 1'b0, 4'h4, 1'b0, 32'h10, 32'h0, 5'd10);
    tick();
    HREADY = 1'b0;
    rst    = 1'b1;
    check_eq("mr_busy_before", {31'b0, busy}, 32'd1);
    tick();
    rst = 1'b0;
    check_eq("mr_htrans", {30'b0, HTRANS}, 32'd0);
    check_eq("mr_busy", {31'b0, busy}, 32'd0);
    check_eq("mr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("mr_haddr", HADDR, 32'd0);
    HREADY = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) pulses++;
      tick();
    end
    check_eq("mr_no_response", pulses, 32'd0);
    HRDATA = 32'h0BADF00D;
    issue(1'b1, 1'b0, 4'h4, 1'b0, 32'h20, 32'h0, 5'd11);
    check_eq("mr_new_haddr", HADDR, 32'h20);
    wait_rsp(1, n, ns);
    check_eq("mr_new_latency", n, 32'd4);
    check_eq("mr_new_data", rsp_data, 32'h0BADF00D);
    check_eq("mr_new_rd_id", {27'b0, rsp_rd_id}, 32'd11);
    after_rsp("mr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/std_lsu_ahb.md
STD_LSU_AHB -- requirements
Module: std_lsu_ahb

Interface
REQ-001 Ports SHALL be as follows; clock `clk` has one domain, and reset `rst` is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock
REQ-003 rst  in  1  synchronous, active-high reset
REQ-004 req_valid  in  1  standard-op memory request present
REQ-005 req_ready  out  1  request accepted this cycle when high with req_valid
REQ-006 req_wr, req_rd  in  1 each  driven from AHB_wr_en / AHB_rd_en
REQ-007 req_size  in  4  byte count; 4'h1 byte, 4'h2 half, 4'h4 word, other values illegal
REQ-008 req_signed  in  1  sign-extend load (LDRSB/LDRSH)
REQ-009 req_addr, req_wdata  in  32 each  byte address; store data in bits [7:0] / [15:0] / [31:0]
REQ-010 req_rd_id  in  5  load destination register id
REQ-011 HADDR  out  32; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  3; HWDATA  out  32  AHB-Lite master outputs
REQ-012 HRDATA  in  32; HREADY  in  1; HRESP  in  1  AHB-Lite slave response
REQ-013 rsp_valid  out  1  one-cycle completion pulse
REQ-014 rsp_data  out  32  extended load data, 0 for stores
REQ-015 rsp_rd_id  out  5; rsp_wb_en  out  1; rsp_err  out  1  register writeback id, enable, and error flag
REQ-016 busy  out  1  high in every state except IDLE

Function
REQ-017 The FSM SHALL have the states IDLE, ADDR, DATA and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; one transfer outstanding at a time.
REQ-019 IDLE with a legal req_valid SHALL latch all req_* fields and go to ADDR.
- Legal means: exactly one of rd/wr, a legal size, and passes the alignment rule (REQ-030).
REQ-020 IDLE with an illegal req_valid SHALL latch it and go directly to RESP.
- rsp_err=1, rsp_wb_en=0, no bus transfer.
REQ-021 ADDR SHALL drive the address phase:
- HTRANS=NONSEQ (2'b10), HADDR, HWRITE, HSIZE (byte 000, half 001, word 010), HBURST=000.
- The state SHALL be held while HREADY=0 and SHALL go to DATA on HREADY=1.
REQ-022 DATA SHALL drive HTRANS=IDLE and, for stores, HWDATA with replicated lanes:
- byte: {4{b}}
- half: {2{h}}
- word: as-is
REQ-023 DATA SHALL wait while HREADY=0, and on HREADY=1 SHALL capture HRDATA and HRESP and go to RESP.
REQ-024 Load data SHALL select lanes by addr[1:0] (little-endian), then zero-extend, or sign-extend when req_signed=1.
REQ-025 RESP SHALL pulse rsp_valid for exactly one cycle and then return to IDLE.
- rsp_wb_en = load AND no error.
- rsp_err = HRESP captured or illegal request.
REQ-026 An error response SHALL complete normally. HRESP=1 with HREADY=0 is followed by HRESP=1 with HREADY=1, and the second cycle completes the transfer with rsp_err=1.
REQ-027 Zero-wait latency SHALL be 4 cycles: accept edge to rsp_valid, with the next req_ready in the following cycle.
REQ-028 Outside ADDR the block SHALL drive HTRANS=IDLE; HADDR, HWDATA and rsp_* SHALL hold their last value except where stated.

Reset
REQ-029 rst SHALL, at the next clock edge and in any state including mid-transfer:
- set the state to IDLE;
- set HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0;
- set rsp_valid=0, rsp_data=0, rsp_rd_id=0, rsp_wb_en=0, rsp_err=0, busy=0;
- set req_ready=1 after rst deasserts.
- An abandoned transfer SHALL produce no response.

Configuration
REQ-030 The feature SHALL be controlled by macro LSU_ALIGN_CHECK_EN.
- Defined: a misaligned half (addr[0]=1) or word (addr[1:0]!=0) request is illegal per REQ-020.
- Undefined: HADDR low bits are cleared per size, the transfer is issued, and a misaligned word load returns HRDATA rotated right by 8*addr[1:0] (ARM7 behaviour).

Verification
REQ-031 Zero-wait word load: addr 0x100, HRDATA 0xDEADBEEF, rd_id 3 -> one HTRANS=10 cycle; rsp_valid 4 cycles after accept; data 0xDEADBEEF; wb_en=1; rd_id=3.
REQ-032 Signed byte load: addr 0x203, req_signed=1, HRDATA 0x80112233 -> rsp_data 0xFFFFFF80; with req_signed=0 -> 0x00000080.
REQ-033 Halfword store with 2 wait states: addr 0x42, wdata 0x0000ABCD -> HSIZE=001; HWDATA 0xABCDABCD held for 3 DATA cycles; rsp_wb_en=0; rsp_err=0.
REQ-034 Error response: word store, slave returns HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> rsp_err=1, rsp_wb_en=0, FSM back in IDLE.
REQ-035 Illegal requests:
- req_rd=req_wr=1 -> no NONSEQ, rsp_err=1 two cycles after accept.
- Word load at 0x101 with macro defined -> rsp_err=1.
- Without the macro: HADDR=0x100 and HRDATA 0x44332211 -> rsp_data 0x11443322.
REQ-036 Reset mid-DATA (HREADY=0): rst for one cycle -> next cycle HTRANS=00, busy=0, no rsp_valid; a new request is then served correctly.
